// File: rtl/ext_lights_pkg.sv
// Shared types for the exterior light array: per-channel state encoding and the dimming PWM width.
package ext_lights_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_ON      = 2'd2,
    ST_ARM_OFF = 2'd3
  } light_state_e;

  localparam int PWM_W = 4;

  // A channel still counts as lit while it is qualifying to turn off.
  function automatic logic is_lit(input light_state_e st);
    return (st == ST_ON) || (st == ST_ARM_OFF);
  endfunction

endpackage

// File: rtl/ext_light_chan.sv
// One light channel: hysteresis FSM with a hold counter that qualifies each transition.
//   state      | meaning
//   ST_OFF     | lamp off, waiting for luminance below the on threshold
//   ST_ARM_ON  | luminance below on threshold, counting qualifying cycles
//   ST_ON      | lamp on, waiting for luminance above the off threshold
//   ST_ARM_OFF | luminance above off threshold, counting qualifying cycles
module ext_light_chan
  import ext_lights_pkg::*;
#(
  parameter int LUM_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [LUM_W-1:0] i_lum,
  input  logic [LUM_W-1:0] i_on_thr,
  input  logic [LUM_W-1:0] i_off_thr,
  input  logic             i_en,
  input  logic             i_cfg_bad,
  output logic             o_lit_nxt
);

  localparam int               CNT_W   = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  light_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    // Disable and bad threshold config both park the channel in OFF.
    if (!i_en || i_cfg_bad) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (i_lum < i_on_thr) begin
            w_state_nxt = ST_ARM_ON;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        ST_ARM_ON: begin
          if (i_lum >= i_on_thr) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_TC) begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_ON: begin
          if (i_lum > i_off_thr) begin
            w_state_nxt = ST_ARM_OFF;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        ST_ARM_OFF: begin
          if (i_lum <= i_off_thr) begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_TC) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_lit_nxt = is_lit(w_state_nxt);

endmodule

// File: rtl/ext_lights_array.sv
// Array of independent exterior light channels with shared thresholds and registered lamp drive.
// Optional dimming PWM on lit channels is enabled by defining EXT_LIGHT_DIM_EN.
module ext_lights_array
  import ext_lights_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int LUM_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [N_CH*LUM_W-1:0] Lum_sen,
  input  logic [LUM_W-1:0]      On_thr,
  input  logic [LUM_W-1:0]      Off_thr,
  input  logic [N_CH-1:0]       Ch_en,
  input  logic [N_CH-1:0]       Force_on,
`ifdef EXT_LIGHT_DIM_EN
  input  logic [PWM_W-1:0]      Dim_level,
`endif
  output logic [N_CH-1:0]       Ext_light,
  output logic                  Cfg_err
);

  logic            w_cfg_bad;
  logic [N_CH-1:0] w_lit_nxt;
  logic [N_CH-1:0] w_light_nxt;
  logic [N_CH-1:0] r_ext_light;
  logic            r_cfg_err;

  // Inverted hysteresis window; channels are held off while it persists.
  assign w_cfg_bad = (Off_thr < On_thr);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    ext_light_chan #(
      .LUM_W    (LUM_W),
      .HOLD_CYC (HOLD_CYC)
    ) u_chan (
      .i_clk     (CLK),
      .i_rst_n   (Reset),
      .i_lum     (Lum_sen[gi*LUM_W +: LUM_W]),
      .i_on_thr  (On_thr),
      .i_off_thr (Off_thr),
      .i_en      (Ch_en[gi]),
      .i_cfg_bad (w_cfg_bad),
      .o_lit_nxt (w_lit_nxt[gi])
    );
  end

`ifdef EXT_LIGHT_DIM_EN
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_pwm_gate;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  assign w_pwm_gate  = (r_pwm_cnt < Dim_level);
  assign w_light_nxt = Force_on | (w_lit_nxt & {N_CH{w_pwm_gate}});
`else
  assign w_light_nxt = Force_on | w_lit_nxt;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_ext_light <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_ext_light <= w_light_nxt;
      r_cfg_err   <= w_cfg_bad;
    end
  end

  assign Ext_light = r_ext_light;
  assign Cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_ext_lights_array.sv
// Self-checking bench for ext_lights_array (default build, N_CH=4, HOLD_CYC=4).
module tb_ext_lights_array;

  localparam int N_CH  = 4;
  localparam int LUM_W = 8;
  localparam int HOLD  = 4;

  logic                  CLK = 1'b0;
  logic                  Reset;
  logic [N_CH*LUM_W-1:0] Lum_sen;
  logic [LUM_W-1:0]      On_thr;
  logic [LUM_W-1:0]      Off_thr;
  logic [N_CH-1:0]       Ch_en;
  logic [N_CH-1:0]       Force_on;
  logic [N_CH-1:0]       Ext_light;
  logic                  Cfg_err;

  ext_lights_array #(
    .N_CH     (N_CH),
    .LUM_W    (LUM_W),
    .HOLD_CYC (HOLD)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Lum_sen   (Lum_sen),
    .On_thr    (On_thr),
    .Off_thr   (Off_thr),
    .Ch_en     (Ch_en),
    .Force_on  (Force_on),
    .Ext_light (Ext_light),
    .Cfg_err   (Cfg_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N_CH-1:0] light;
    logic            cfg;
  } exp_t;

  exp_t sb_q[$];
  int   m_st [N_CH];
  int   m_cnt[N_CH];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_st[i]  = 0;
      m_cnt[i] = 0;
    end
  endtask

  // Reference behaviour: 0=OFF 1=ARM_ON 2=ON 3=ARM_OFF
  task automatic model_step(output exp_t e);
    int lum;
    e.cfg   = (Off_thr < On_thr);
    e.light = '0;
    for (int i = 0; i < N_CH; i++) begin
      lum = int'(Lum_sen[i*LUM_W +: LUM_W]);
      if (!Ch_en[i] || e.cfg) begin
        m_st[i] = 0; m_cnt[i] = 0;
      end else begin
        case (m_st[i])
          0: if (lum < int'(On_thr)) begin m_st[i] = 1; m_cnt[i] = 1; end
          1: if (lum >= int'(On_thr)) begin m_st[i] = 0; m_cnt[i] = 0; end
             else if (m_cnt[i] == HOLD) begin m_st[i] = 2; m_cnt[i] = 0; end
             else m_cnt[i]++;
          2: if (lum > int'(Off_thr)) begin m_st[i] = 3; m_cnt[i] = 1; end
          default: if (lum <= int'(Off_thr)) begin m_st[i] = 2; m_cnt[i] = 0; end
             else if (m_cnt[i] == HOLD) begin m_st[i] = 0; m_cnt[i] = 0; end
             else m_cnt[i]++;
        endcase
      end
      e.light[i] = Force_on[i] | (m_st[i] >= 2);
    end
  endtask

  task automatic step(input int n = 1);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      model_step(e);
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      check_eq("sb_light", 32'(Ext_light), 32'(e.light));
      check_eq("sb_cfg", 32'(Cfg_err), 32'(e.cfg));
    end
  endtask

  task automatic set_lum(input int ch, input int val);
    Lum_sen[ch*LUM_W +: LUM_W] = LUM_W'(val);
  endtask

  task automatic set_all(input int val);
    for (int i = 0; i < N_CH; i++) set_lum(i, val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    Reset    = 1'b0;
    On_thr   = 8'd30;
    Off_thr  = 8'd60;
    Ch_en    = 4'hF;
    Force_on = 4'h0;
    Lum_sen  = '0;
    set_all(90);
    model_reset();
    #2;
    check_eq("rst_light", 32'(Ext_light), 32'h0);
    check_eq("rst_cfg", 32'(Cfg_err), 32'h0);
    @(posedge CLK);
    #3 Reset = 1'b1;

    // Bright ambient: nothing lights, no config error
    step(20);
    check_eq("bright_off", 32'(Ext_light), 32'h0);

    // Ch0 dark: light appears on the edge HOLD after the first sampling edge
    set_lum(0, 20);
    step(HOLD);
    check_eq("ch0_pre", 32'(Ext_light[0]), 32'h0);
    step(1);
    check_eq("ch0_rise", 32'(Ext_light[0]), 32'h1);
    check_eq("ch0_others", 32'(Ext_light[3:1]), 32'h0);

    // Ch1 short dark glitch does not arm through; a sustained run does
    set_lum(1, 20);
    step(3);
    set_lum(1, 90);
    step(3);
    check_eq("ch1_glitch", 32'(Ext_light[1]), 32'h0);
    set_lum(1, 20);
    step(HOLD);
    check_eq("ch1_pre", 32'(Ext_light[1]), 32'h0);
    step(1);
    check_eq("ch1_on", 32'(Ext_light[1]), 32'h1);

    // Hysteresis band and exact-threshold values
    set_lum(0, 45);
    set_lum(3, 30);
    step(10);
    check_eq("ch0_band", 32'(Ext_light[0]), 32'h1);
    check_eq("ch3_eq_on", 32'(Ext_light[3]), 32'h0);
    set_lum(0, 60);
    step(8);
    check_eq("ch0_eq_off", 32'(Ext_light[0]), 32'h1);
    set_lum(0, 90);
    set_lum(3, 90);
    step(HOLD);
    check_eq("ch0_still_on", 32'(Ext_light[0]), 32'h1);
    step(1);
    check_eq("ch0_off", 32'(Ext_light[0]), 32'h0);

    // Manual override does not touch the FSM
    Force_on = 4'b0100;
    step(1);
    check_eq("force2_on", 32'(Ext_light[2]), 32'h1);
    Force_on = 4'b0000;
    step(1);
    check_eq("force2_off", 32'(Ext_light[2]), 32'h0);

    // Channel disable while lit
    set_lum(0, 20);
    step(HOLD + 1);
    check_eq("ch0_relit", 32'(Ext_light[0]), 32'h1);
    Ch_en = 4'b1110;
    step(1);
    check_eq("ch0_dis", 32'(Ext_light[0]), 32'h0);
    check_eq("ch1_indep", 32'(Ext_light[1]), 32'h1);
    step(2);
    Ch_en = 4'hF;
    step(2);

    // Inverted thresholds: error flag and all channels forced off
    On_thr  = 8'd70;
    Off_thr = 8'd50;
    step(1);
    check_eq("cfg_err_set", 32'(Cfg_err), 32'h1);
    check_eq("cfg_err_dark", 32'(Ext_light), 32'h0);
    step(3);
    On_thr  = 8'd30;
    Off_thr = 8'd60;
    step(1);
    check_eq("cfg_err_clr", 32'(Cfg_err), 32'h0);
    step(HOLD + 2);
    check_eq("cfg_resume", 32'(Ext_light[1:0]), 32'h3);

    // Async reset mid-ARM_ON on ch2 while ch1 is lit
    set_lum(2, 20);
    step(2);
    #2 Reset = 1'b0;
    #1;
    check_eq("mid_rst_light", 32'(Ext_light), 32'h0);
    check_eq("mid_rst_cfg", 32'(Cfg_err), 32'h0);
    model_reset();
    @(posedge CLK);
    #3 Reset = 1'b1;
    step(HOLD);
    check_eq("post_rst_pre", 32'(Ext_light[2]), 32'h0);
    step(1);
    check_eq("post_rst_on", 32'(Ext_light[2]), 32'h1);

    // Random luminance / control traffic against the model
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 3) == 0) set_lum(i, $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(25, 90));
      end
      if ($urandom_range(0, 15) == 0) Ch_en = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) Ch_en = 4'hF;
      Force_on = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
